// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 scancode-set-2 key decoder.
// Prefix-FSM encoding, special scancodes, ignore-byte list and the 19-bit event record.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } kbd_state_e;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] SC_CAPS    = 8'h58;

  // Keyboard status/ack bytes that never form a key event.
  localparam int              N_IGNORE    = 5;
  localparam logic [8*N_IGNORE-1:0] IGNORE_LIST = {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF};

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic       rpt;
    logic [7:0] code;
    logic [7:0] ascii;
  } kbd_event_t;

  function automatic logic is_ignore(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_IGNORE; i++) begin
      if (b == IGNORE_LIST[i*8 +: 8]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational scancode-set-2 to lowercase ASCII table (digits and letters).
// Unmapped codes return 0x00; case adjustment happens in the parent.
module ps2_ascii_lut (
  input  logic [7:0] code_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    ascii_o = 8'h00;
    case (code_i)
      8'h45: ascii_o = "0";
      8'h16: ascii_o = "1";
      8'h1E: ascii_o = "2";
      8'h26: ascii_o = "3";
      8'h25: ascii_o = "4";
      8'h2E: ascii_o = "5";
      8'h36: ascii_o = "6";
      8'h3D: ascii_o = "7";
      8'h3E: ascii_o = "8";
      8'h46: ascii_o = "9";
      8'h1C: ascii_o = "a";
      8'h32: ascii_o = "b";
      8'h21: ascii_o = "c";
      8'h23: ascii_o = "d";
      8'h24: ascii_o = "e";
      8'h2B: ascii_o = "f";
      8'h34: ascii_o = "g";
      8'h33: ascii_o = "h";
      8'h43: ascii_o = "i";
      8'h3B: ascii_o = "j";
      8'h42: ascii_o = "k";
      8'h4B: ascii_o = "l";
      8'h3A: ascii_o = "m";
      8'h31: ascii_o = "n";
      8'h44: ascii_o = "o";
      8'h4D: ascii_o = "p";
      8'h15: ascii_o = "q";
      8'h2D: ascii_o = "r";
      8'h1B: ascii_o = "s";
      8'h2C: ascii_o = "t";
      8'h3C: ascii_o = "u";
      8'h2A: ascii_o = "v";
      8'h1D: ascii_o = "w";
      8'h22: ascii_o = "x";
      8'h35: ascii_o = "y";
      8'h1A: ascii_o = "z";
      default: ascii_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 decoder: E0/F0 prefix FSM, held-key/typematic tracking, ASCII, event FIFO.
// Optional KBD_SHIFT_EN adds shift/caps-lock tracking for letter case.
module ps2_key_decoder
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_code,
  output logic [7:0]                    out_ascii,
  output logic                          out_ext,
  output logic                          out_break,
  output logic                          out_repeat,
  output logic                          held,
  output logic [7:0]                    held_code,
  output logic [CNT_W-1:0]              press_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic             byte_vld_q;
  logic [7:0]       byte_q;
  kbd_state_e       state_q, state_d;
  logic             held_q, held_ext_q;
  logic [7:0]       held_code_q;
  logic [CNT_W-1:0] press_q;
  logic             ovf_q;
  kbd_event_t       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [LW-1:0]    level_q, level_d;

  logic             ev_valid, ev_ext, ev_brk, ev_rpt;
  logic [7:0]       lut_ascii, ev_ascii;
  logic             is_letter, case_flip;
  logic             push, pop, full;
  kbd_event_t       ev, head_ev;

  // The incoming byte is registered first; all decoding works on the registered copy.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      byte_vld_q <= 1'b0;
      byte_q     <= 8'h00;
    end else begin
      byte_vld_q <= in_valid;
      byte_q     <= in_data;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ev_valid = 1'b0;
    ev_ext   = 1'b0;
    ev_brk   = 1'b0;
    if (byte_vld_q) begin
      if (byte_q == PREFIX_EXT) begin
        state_d = EXT;
      end else if (byte_q == PREFIX_BRK) begin
        if (state_q == IDLE)     state_d = BRK;
        else if (state_q == EXT) state_d = EXT_BRK;
      end else if (is_ignore(byte_q)) begin
        state_d = IDLE;
      end else begin
        ev_valid = 1'b1;
        ev_ext   = (state_q == EXT) || (state_q == EXT_BRK);
        ev_brk   = (state_q == BRK) || (state_q == EXT_BRK);
        state_d  = IDLE;
      end
    end
  end

  assign ev_rpt = ev_valid && !ev_brk && held_q &&
                  (byte_q == held_code_q) && (ev_ext == held_ext_q);

  ps2_ascii_lut u_lut (
    .code_i  (byte_q),
    .ascii_o (lut_ascii)
  );

  assign is_letter = (lut_ascii >= 8'h61) && (lut_ascii <= 8'h7A);

`ifdef KBD_SHIFT_EN
  logic lshift_q, rshift_q, caps_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      caps_q   <= 1'b0;
    end else if (ev_valid && !ev_ext) begin
      if (byte_q == SC_LSHIFT) lshift_q <= !ev_brk;
      if (byte_q == SC_RSHIFT) rshift_q <= !ev_brk;
      if (byte_q == SC_CAPS && !ev_brk && !ev_rpt) caps_q <= !caps_q;
    end
  end

  assign case_flip = (lshift_q | rshift_q) ^ caps_q;
`else
  assign case_flip = 1'b0;
`endif

  assign ev_ascii = ev_ext ? 8'h00 :
                    (is_letter && case_flip) ? (lut_ascii - 8'h20) : lut_ascii;

  assign ev = '{ext: ev_ext, brk: ev_brk, rpt: ev_rpt, code: byte_q, ascii: ev_ascii};

  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign pop     = out_valid && out_ready;
  assign push    = ev_valid && (!full || pop);
  assign level_d = level_q + LW'(push) - LW'(pop);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      held_q      <= 1'b0;
      held_ext_q  <= 1'b0;
      held_code_q <= 8'h00;
      press_q     <= '0;
      ovf_q       <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      if (ev_valid && !ev_brk) begin
        held_q      <= 1'b1;
        held_code_q <= byte_q;
        held_ext_q  <= ev_ext;
        if (!ev_rpt) press_q <= press_q + CNT_W'(1);
      end else if (ev_valid && held_q && byte_q == held_code_q && ev_ext == held_ext_q) begin
        held_q      <= 1'b0;
        held_code_q <= 8'h00;
        held_ext_q  <= 1'b0;
      end
      if (ev_valid && !push) ovf_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Entries are cleared on reset so the head fields read zero out of reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= ev;
    end
  end

  assign head_ev     = mem_q[rd_ptr_q];
  assign out_valid   = (level_q != '0);
  assign out_code    = head_ev.code;
  assign out_ascii   = head_ev.ascii;
  assign out_ext     = head_ev.ext;
  assign out_break   = head_ev.brk;
  assign out_repeat  = head_ev.rpt;
  assign held        = held_q;
  assign held_code   = held_code_q;
  assign press_count = press_q;
  assign fifo_level  = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus random bytes,
// checked every cycle against a queue-based event model (honours KBD_SHIFT_EN).
module tb_ps2_key_decoder;

  localparam int DEPTH = 8;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          clrn = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          out_ready = 1'b0;
  logic          out_valid, out_ext, out_break, out_repeat, held, overflow;
  logic [7:0]    out_code, out_ascii, held_code;
  logic [CW-1:0] press_count;
  logic [3:0]    fifo_level;

  always #5 clk = ~clk;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code),
    .out_ascii   (out_ascii),
    .out_ext     (out_ext),
    .out_break   (out_break),
    .out_repeat  (out_repeat),
    .held        (held),
    .held_code   (held_code),
    .press_count (press_count),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
  );

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic       rpt;
    logic [7:0] code;
    logic [7:0] ascii;
  } ev_t;

  int checks = 0;
  int errors = 0;

  ev_t        mq[$];
  bit         m_ext, m_brk, m_held, m_held_ext, m_ovf;
  logic [7:0] m_held_code, m_press;
  bit         pend_v;
  logic [7:0] pend_d;
`ifdef KBD_SHIFT_EN
  bit         m_lsh, m_rsh, m_caps;
`endif

  logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] ign_codes [5]  = '{8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF};
  logic [7:0] mod_codes [3]  = '{8'h12, 8'h59, 8'h58};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ascii_of(input logic [7:0] code, input bit ext);
    logic [7:0] a;
    bit upper;
    a = 8'h00;
    upper = 1'b0;
`ifdef KBD_SHIFT_EN
    upper = (m_lsh | m_rsh) ^ m_caps;
`endif
    if (!ext) begin
      for (int i = 0; i < 10; i++) if (dig_codes[i] == code) a = 8'h30 + 8'(i);
      for (int i = 0; i < 26; i++) if (let_codes[i] == code) a = (upper ? 8'h41 : 8'h61) + 8'(i);
    end
    return a;
  endfunction

  // Model of one clock edge: the byte driven last cycle is decoded now.
  task automatic model_edge(input bit rdy);
    bit  pop, have_ev;
    ev_t e;
    pop = (mq.size() != 0) && rdy;
    have_ev = 1'b0;
    e = '0;
    if (pend_v) begin
      if (pend_d == 8'hE0) begin
        m_ext = 1'b1; m_brk = 1'b0;
      end else if (pend_d == 8'hF0) begin
        m_brk = 1'b1;
      end else if (pend_d inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF}) begin
        m_ext = 1'b0; m_brk = 1'b0;
      end else begin
        e.code  = pend_d;
        e.ext   = m_ext;
        e.brk   = m_brk;
        e.ascii = ascii_of(pend_d, m_ext);
        e.rpt   = !m_brk && m_held && (m_held_code == pend_d) && (m_held_ext == m_ext);
        have_ev = 1'b1;
        m_ext = 1'b0; m_brk = 1'b0;
        if (!e.brk) begin
          if (!e.rpt) m_press = m_press + 8'd1;
          m_held = 1'b1; m_held_code = e.code; m_held_ext = e.ext;
        end else if (m_held && m_held_code == e.code && m_held_ext == e.ext) begin
          m_held = 1'b0; m_held_code = 8'h00; m_held_ext = 1'b0;
        end
`ifdef KBD_SHIFT_EN
        if (!e.ext) begin
          if (e.code == 8'h12) m_lsh = !e.brk;
          if (e.code == 8'h59) m_rsh = !e.brk;
          if (e.code == 8'h58 && !e.brk && !e.rpt) m_caps = !m_caps;
        end
`endif
      end
    end
    if (pop) void'(mq.pop_front());
    if (have_ev) begin
      if (mq.size() < DEPTH) mq.push_back(e);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_state();
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("held", 32'(held), 32'(m_held));
    chk("held_code", 32'(held_code), 32'(m_held_code));
    chk("press_count", 32'(press_count), 32'(m_press));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() != 0)
      chk("head_event", 32'({out_ext, out_break, out_repeat, out_code, out_ascii}), 32'(mq[0]));
  endtask

  // One cycle: check state at the negedge, drive inputs, advance model, wait one period.
  task automatic step(input bit v, input logic [7:0] d, input bit rdy);
    check_state();
    in_valid = v; in_data = d; out_ready = rdy;
    model_edge(rdy);
    pend_v = v; pend_d = d;
    $display("step v=%0b data=%h rdy=%0b level=%0d", v, d, rdy, mq.size());
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    clrn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_fields", 32'({out_code, out_ascii, out_ext, out_break, out_repeat}), 32'd0);
    chk("rst_held", 32'({held, held_code}), 32'd0);
    chk("rst_press_count", 32'(press_count), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    mq.delete();
    m_ext = 0; m_brk = 0; m_held = 0; m_held_ext = 0; m_ovf = 0;
    m_held_code = 8'h00; m_press = 8'h00; pend_v = 0; pend_d = 8'h00;
`ifdef KBD_SHIFT_EN
    m_lsh = 0; m_rsh = 0; m_caps = 0;
`endif
    $display("reset applied");
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic peek(input string tag, input ev_t exp);
    chk(tag, 32'({out_ext, out_break, out_repeat, out_code, out_ascii}), 32'(exp));
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    case ($urandom_range(0, 9))
      0:       b = 8'hE0;
      1, 2:    b = 8'hF0;
      3:       b = ign_codes[$urandom_range(0, 4)];
      4:       b = mod_codes[$urandom_range(0, 2)];
      5:       b = 8'($urandom);
      6:       b = dig_codes[$urandom_range(0, 9)];
      default: b = let_codes[$urandom_range(0, 25)];
    endcase
    return b;
  endfunction

  logic [7:0] seq_t2 [8]  = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hF0, 8'hE0, 8'h75};
  logic [7:0] seq_t3 [5]  = '{8'h16, 8'h16, 8'h16, 8'hF0, 8'h16};
  logic [7:0] seq_t4 [9]  = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
  logic [7:0] seq_t5 [8]  = '{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h58, 8'hF0, 8'h58, 8'h1C};
`ifdef KBD_SHIFT_EN
  logic [7:0] asc_t5 [6]  = '{8'h00, 8'h41, 8'h00, 8'h00, 8'h00, 8'h41};
`else
  logic [7:0] asc_t5 [6]  = '{8'h00, 8'h61, 8'h00, 8'h00, 8'h00, 8'h61};
`endif
  logic       rpt_t3 [4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       brk_t3 [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    @(negedge clk);
    do_reset();

    // Make/break of 'a' with one-cycle decode latency.
    step(1'b1, 8'h1C, 1'b0);
    chk("t1_latency_valid_low", 32'(out_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    chk("t1_latency_valid_high", 32'(out_valid), 32'd1);
    peek("t1_make", '{ext: 1'b0, brk: 1'b0, rpt: 1'b0, code: 8'h1C, ascii: 8'h61});
    step(1'b1, 8'hF0, 1'b1);
    step(1'b1, 8'h1C, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    peek("t1_break", '{ext: 1'b0, brk: 1'b1, rpt: 1'b0, code: 8'h1C, ascii: 8'h61});
    chk("t1_held_cleared", 32'(held), 32'd0);
    chk("t1_press_count", 32'(press_count), 32'd1);
    idle(2, 1'b1);

    // Extended make/break, then a bare F0 overridden by E0.
    do_reset();
    foreach (seq_t2[i]) step(1'b1, seq_t2[i], 1'b0);
    idle(2, 1'b0);
    chk("t2_level", 32'(fifo_level), 32'd3);
    peek("t2_ext_make", '{ext: 1'b1, brk: 1'b0, rpt: 1'b0, code: 8'h75, ascii: 8'h00});
    step(1'b0, 8'h00, 1'b1);
    peek("t2_ext_break", '{ext: 1'b1, brk: 1'b1, rpt: 1'b0, code: 8'h75, ascii: 8'h00});
    step(1'b0, 8'h00, 1'b1);
    peek("t2_f0_e0_make", '{ext: 1'b1, brk: 1'b0, rpt: 1'b0, code: 8'h75, ascii: 8'h00});
    step(1'b0, 8'h00, 1'b1);

    // Typematic repeats of '1'.
    do_reset();
    foreach (seq_t3[i]) step(1'b1, seq_t3[i], 1'b0);
    idle(2, 1'b0);
    chk("t3_level", 32'(fifo_level), 32'd4);
    chk("t3_press_count", 32'(press_count), 32'd1);
    for (int i = 0; i < 4; i++) begin
      peek($sformatf("t3_event%0d", i),
           '{ext: 1'b0, brk: brk_t3[i], rpt: rpt_t3[i], code: 8'h16, ascii: 8'h31});
      step(1'b0, 8'h00, 1'b1);
    end

    // Overflow: nine makes into an 8-deep FIFO, then drain in order.
    do_reset();
    foreach (seq_t4[i]) step(1'b1, seq_t4[i], 1'b0);
    idle(2, 1'b0);
    chk("t4_level_full", 32'(fifo_level), 32'd8);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_press_count", 32'(press_count), 32'd9);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_drain%0d", i), 32'(out_code), 32'(seq_t4[i]));
      step(1'b0, 8'h00, 1'b1);
    end
    chk("t4_overflow_sticky", 32'(overflow), 32'd1);

    // Full FIFO with simultaneous push and pop keeps the level.
    do_reset();
    foreach (seq_t4[i]) if (i < 8) step(1'b1, seq_t4[i], 1'b0);
    step(1'b1, 8'h4B, 1'b0);
    chk("t4b_level_full", 32'(fifo_level), 32'd8);
    step(1'b0, 8'h00, 1'b1);
    chk("t4b_level_same", 32'(fifo_level), 32'd8);
    chk("t4b_no_overflow", 32'(overflow), 32'd0);

    // Shift / caps sequence (lowercase when the feature is absent).
    do_reset();
    foreach (seq_t5[i]) step(1'b1, seq_t5[i], 1'b0);
    idle(2, 1'b0);
    chk("t5_level", 32'(fifo_level), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t5_ascii%0d", i), 32'(out_ascii), 32'(asc_t5[i]));
      step(1'b0, 8'h00, 1'b1);
    end

    // Reset in the middle of a break sequence.
    do_reset();
    step(1'b1, 8'h1C, 1'b1);
    step(1'b1, 8'hF0, 1'b1);
    do_reset();
    step(1'b1, 8'h1C, 1'b0);
    idle(2, 1'b0);
    chk("t6_level", 32'(fifo_level), 32'd1);
    peek("t6_make", '{ext: 1'b0, brk: 1'b0, rpt: 1'b0, code: 8'h1C, ascii: 8'h61});

    // Random byte stream with random back-pressure.
    do_reset();
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 3) != 0), rand_byte(), ($urandom_range(0, 2) != 0));
    idle(12, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Sequential PS/2 scancode-set-2 decoder placed between the PS/2 byte receiver and the display/console logic. It consumes raw scancode bytes and resolves the E0 (extended) and F0 (break) prefixes. It tracks the held key and typematic repeats, translates digits and letters to ASCII, and buffers complete key events in a parametrised FIFO with a valid/ready output handshake.

## Interface
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥2
- CNT_W, 8, width of the key-press counter
- clk  in  1  single clock, rising edge
- clrn  in  1  asynchronous active-low reset
- in_valid  in  1  one raw scancode byte this cycle
- in_data  in  8  raw scancode byte
- out_valid  out  1  FIFO head holds an event
- out_ready  in  1  consumer accepts the head event
- out_code  out  8  scancode of the head event (prefixes stripped)
- out_ascii  out  8  ASCII of the head event; 0x00 if unmapped
- out_ext  out  1  event was E0-prefixed
- out_break  out  1  event is a release
- out_repeat  out  1  make event is a typematic repeat of the held key
- held  out  1  a key is currently held
- held_code  out  8  code of the held key; 0x00 when none
- press_count  out  CNT_W  count of non-repeat make events, wrapping
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries
- overflow  out  1  sticky: an event was dropped because the FIFO was full

## Operation
- Prefix FSM with states IDLE, EXT, BRK and EXT_BRK; transitions are taken only on in_valid.
  - E0 from any state goes to EXT. A pending break is discarded.
  - F0: IDLE→BRK, EXT→EXT_BRK; BRK and EXT_BRK stay where they are.
  - 0x00, 0xAA, 0xFA, 0xFE and 0xFF: no event; go to IDLE.
  - Any other byte completes an event: ext = (state∈{EXT,EXT_BRK}), break = (state∈{BRK,EXT_BRK}). Go to IDLE.
- Repeat detection: a make event is a repeat if held=1, its code equals held_code and its ext matches the held ext.
- Held-key update:
  - A make event sets held=1 and updates held_code and the held ext.
  - A break event matching held_code and the held ext clears held and sets held_code=0x00.
  - A break event for a non-matching key leaves the held state unchanged.
- press_count increments by 1 on each non-repeat make event. It wraps modulo 2^CNT_W and increments even when the event is dropped.
- ASCII mapping:
  - Applies only to non-extended events; extended events give 0x00.
  - Main-block digits: 45→'0', 16→'1', 1E→'2', 26→'3', 25→'4', 2E→'5', 36→'6', 3D→'7', 3E→'8', 46→'9'.
  - Letters a–z: 1C→a, 32→b, 21→c, 23→d, 24→e, 2B→f, 34→g, 33→h, 43→i, 3B→j, 42→k, 4B→l, 3A→m, 31→n, 44→o, 4D→p, 15→q, 2D→r, 1B→s, 2C→t, 3C→u, 2A→v, 1D→w, 22→x, 35→y, 1A→z.
  - Every other code gives 0x00.
  - Break events carry the same ASCII as the corresponding make would.
- FIFO:
  - A completed event is pushed if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow is set. overflow clears only on reset.
  - Pop occurs when out_valid & out_ready.
  - out_* fields are undefined-but-stable while out_valid=0; drive them from the head entry.

## Timing
- Reset values: all FSM state and flags clear, state = IDLE.
  - out_valid=0, out_code=0, out_ascii=0, out_ext=0, out_break=0, out_repeat=0.
  - held=0, held_code=0, press_count=0, fifo_level=0, overflow=0.
- Latency: a completing byte sampled on edge N gives out_valid=1 after edge N+1 when the FIFO was empty. Prefix bytes produce no output.
- held, held_code and press_count update on the same edge as the push decision.
- Full FIFO with simultaneous push and pop: both occur, and fifo_level is unchanged.
- out_valid is held, with a stable head, until accepted.
- Asynchronous reset mid-sequence (e.g. after F0) discards the prefix and all FIFO contents.

## Configuration
- KBD_SHIFT_EN defined:
  - The decoder tracks shift = (L-shift 12 held) | (R-shift 59 held), using non-extended make/break events.
  - A non-repeat make of 58 (Caps Lock) toggles caps.
  - Letter ASCII has 0x20 subtracted when shift^caps.
  - Digits are unaffected.
  - shift and caps reset to 0.
- KBD_SHIFT_EN undefined: no shift or caps state is kept; letters are always lowercase. Shift and caps keys still generate normal events with ASCII 0x00.

## Structure
- Package kbd_pkg holds:
  - the FSM state encoding;
  - the constants PREFIX_EXT=E0, PREFIX_BRK=F0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CAPS=58;
  - the ignore-byte list;
  - the event record layout (ext, break, repeat, code[8], ascii[8]; 19 bits).
- Sub-module ps2_ascii_lut: combinational code→lowercase ASCII table. The shift/caps adjustment is applied in the parent.

## Test plan
- Bytes 1C, F0, 1C with out_ready=1 → event {code 1C, ascii 61, break 0, repeat 0}, then {1C, 61, break 1}; held returns to 0; press_count=1.
- Bytes E0, 75, E0, F0, 75 → events {75, ext 1, ascii 00, break 0} and {75, ext 1, break 1}. A bare F0 E0 75 gives a make event with ext=1 and break=0.
- Bytes 16, 16, 16, F0, 16 → the repeat flags on the three makes are 0, 1, 1; press_count=1; held_code=16 until the break.
- out_ready=0, FIFO_DEPTH=8, nine make bytes → fifo_level=8, overflow=1, press_count=9; draining returns the first 8 events in order.
- With KBD_SHIFT_EN: 12, 1C, F0, 12, 58, F0, 58, 1C → ASCII values 00, 41, 00, 00, 00, 41.
- Drive 1C and F0, assert clrn=0 for one cycle, then 1C → out_valid=0 during reset, then a single make event {1C, break 0}.
